// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment codes
// (a..g, MSB = a), digit-select patterns and the FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

    // Legal only when exactly one digit enable is driven low.
    function automatic logic an_legal(input logic [3:0] an);
        logic ok;
        case (an)
            AN_DIG0, AN_DIG1, AN_DIG2, AN_DIG3: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            AN_DIG0: idx = 2'd0;
            AN_DIG1: idx = 2'd1;
            AN_DIG2: idx = 2'd2;
            AN_DIG3: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational reverse of the hex-to-7-segment encoder; unknown patterns
// decode to zero with the invalid flag raised.
module seg_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       invalid
);

    // Table lookup; dp is not part of the pattern.
    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: begin
                nibble  = 4'h0;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, waits for each digit strobe to settle,
// decodes the shown digit and publishes complete 4-digit frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE = 16,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [3:0]  AN,
    input  logic [7:0]  dig,
    output logic [15:0] Data,
    output logic        Valid,
    output logic        Err,
    output logic [3:0]  Digit_Err,
    output logic [7:0]  Frame_Cnt
);

    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

    scan_state_e      state_q, state_d;
    logic [3:0]       an_q, an_prev_q;
    logic [7:0]       dig_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       derr_q, derr_d;
    logic [15:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [3:0]       digit_err_q, digit_err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic [3:0]       nib_s;
    logic             inv_s;
    logic             legal_s, changed_s, capture_s, frame_done_s;
    logic [1:0]       idx_s;
    logic [3:0]       mask_base_s, derr_base_s;

    seg_to_hex u_seg_to_hex (
        .seg     (dig_q[7:1]),
        .nibble  (nib_s),
        .invalid (inv_s)
    );

    // Next-state: settle FSM, capture into the shadow word, frame hand-off.
    always_comb begin
        legal_s      = an_legal(an_q);
        idx_s        = an_index(an_q);
        changed_s    = (an_q != an_prev_q);
        frame_done_s = (mask_q == 4'hF);
        capture_s    = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        err_d        = err_q;
        digit_err_d  = digit_err_q;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            ST_WAIT: begin
                if (!legal_s || changed_s) begin
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_M1) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                cnt_d = '0;
                if (!legal_s || changed_s) begin
                    state_d = ST_WAIT;
                end else begin
                    capture_s = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_d = '0;
                if (!legal_s || changed_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
        endcase

        // Clearing the mask and a fresh capture may coincide; the capture
        // lands in the new frame.
        if (frame_done_s) begin
            data_d      = shadow_q;
            digit_err_d = derr_q;
            err_d       = |derr_q;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            mask_base_s = 4'h0;
            derr_base_s = 4'h0;
        end else begin
            mask_base_s = mask_q;
            derr_base_s = derr_q;
        end

        mask_d = mask_base_s;
        derr_d = derr_base_s;
        if (capture_s) begin
            shadow_d[{idx_s, 2'b00} +: 4] = nib_s;
            mask_d[idx_s]                 = 1'b1;
            derr_d[idx_s]                 = inv_s;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            an_q        <= 4'hF;
            an_prev_q   <= 4'hF;
            dig_q       <= 8'hFF;
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            shadow_q    <= 16'h0000;
            mask_q      <= 4'h0;
            derr_q      <= 4'h0;
            data_q      <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            digit_err_q <= 4'h0;
            frame_cnt_q <= 8'h00;
        end else begin
            an_q        <= AN;
            an_prev_q   <= an_q;
            dig_q       <= dig;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            mask_q      <= mask_d;
            derr_q      <= derr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            digit_err_q <= digit_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign Data      = data_q;
    assign Valid     = valid_q;
    assign Err       = err_q;
    assign Digit_Err = digit_err_q;
    assign Frame_Cnt = frame_cnt_q;

endmodule
